// File: rtl/edge_slope_setup.sv
// Triangle setup: forms dx/dy for the three edges, runs one division per edge
// through the external divider, and presents fixed-point slopes plus edge flags.
module edge_slope_setup #(
   parameter int FRAC_BITS      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] v0_x,
   input  logic signed [15:0] v0_y,
   input  logic signed [15:0] v1_x,
   input  logic signed [15:0] v1_y,
   input  logic signed [15:0] v2_x,
   input  logic signed [15:0] v2_y,
   output logic               div_open,
   output logic signed [20:0] div_dividend,
   output logic signed [20:0] div_divisor,
   input  logic               div_finish,
   input  logic signed [20:0] div_quotient,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [20:0] slope0,
   output logic signed [20:0] slope1,
   output logic signed [20:0] slope2,
   output logic [2:0]         horiz,
   output logic [2:0]         timeout_err
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [2:0][15:0]  x_q, x_d, y_q, y_d;
   logic [2:0][20:0]  slope_q, slope_d;
   logic [2:0]        horiz_q, horiz_d, terr_q, terr_d;
   logic [20:0]       dvd_q, dvd_d, dvs_q, dvs_d;

   logic [2:0][20:0]  dvd_e, dvs_e;
   logic [2:0]        dy_zero;
   logic [20:0]       cur_dvd, cur_dvs, edge_val;
   logic              cur_zero, edge_end;
   logic [2:0]        sel;

   // Edge k runs from vertex k to vertex (k+1)%3.
   for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      localparam int NB = (gi + 1) % 3;
      logic [16:0] dx, dy;
      assign dx          = {x_q[NB][15], x_q[NB]} - {x_q[gi][15], x_q[gi]};
      assign dy          = {y_q[NB][15], y_q[NB]} - {y_q[gi][15], y_q[gi]};
      assign dvd_e[gi]   = {{4{dx[16]}}, dx} << FRAC_BITS;
      assign dvs_e[gi]   = {{4{dy[16]}}, dy};
      assign dy_zero[gi] = (dy == 17'd0);
   end

   always_comb begin
      cur_dvd  = dvd_e[2];
      cur_dvs  = dvs_e[2];
      cur_zero = dy_zero[2];
      if (idx_q == 2'd0) begin
         cur_dvd  = dvd_e[0];
         cur_dvs  = dvs_e[0];
         cur_zero = dy_zero[0];
      end else if (idx_q == 2'd1) begin
         cur_dvd  = dvd_e[1];
         cur_dvs  = dvs_e[1];
         cur_zero = dy_zero[1];
      end
   end

   assign sel          = 3'b001 << idx_q;
   assign in_ready     = (state_q == S_IDLE);
   assign out_valid    = (state_q == S_DONE);
   assign div_open     = (state_q == S_ISSUE) && !cur_zero;
   // Operands go out combinationally in the open cycle, then hold from the registers.
   assign div_dividend = div_open ? cur_dvd : dvd_q;
   assign div_divisor  = div_open ? cur_dvs : dvs_q;
   assign slope0       = slope_q[0];
   assign slope1       = slope_q[1];
   assign slope2       = slope_q[2];
   assign horiz        = horiz_q;
   assign timeout_err  = terr_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      slope_d  = slope_q;
      horiz_d  = horiz_q;
      terr_d   = terr_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      edge_end = 1'b0;
      edge_val = '0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = {v2_x, v1_x, v0_x};
               y_d     = {v2_y, v1_y, v0_y};
               horiz_d = '0;
               terr_d  = '0;
               idx_d   = 2'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cur_zero) begin
               horiz_d  = horiz_q | sel;
               edge_end = 1'b1;
            end else begin
               dvd_d   = cur_dvd;
               dvs_d   = cur_dvs;
               cnt_d   = 8'd0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (div_finish) begin
               edge_end = 1'b1;
               edge_val = div_quotient;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               terr_d   = terr_q | sel;
               edge_end = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (edge_end) begin
         for (int k = 0; k < 3; k++) begin
            if (sel[k]) slope_d[k] = edge_val;
         end
         if (idx_q == 2'd2) begin
            state_d = S_DONE;
         end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_ISSUE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         slope_q <= '0;
         horiz_q <= '0;
         terr_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         slope_q <= slope_d;
         horiz_q <= horiz_d;
         terr_q  <= terr_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
      end
   end
endmodule

// File: tb/tb_edge_slope_setup.sv
// Bench for edge_slope_setup: table vectors, corner sequences and random
// triangles against a behavioural divider with programmable latency.
module tb_edge_slope_setup;
   localparam int FRAC = 4;
   localparam int TO   = 64;

   typedef struct {
      int         x[3];
      int         y[3];
      int         lat;   // divider latency; 0 = never answers, -1 = random 1..20
      int         s[3];
      logic [2:0] hz;
      logic [2:0] te;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
   logic               div_open;
   logic signed [20:0] div_dividend, div_divisor;
   logic               div_finish = 1'b0;
   logic signed [20:0] div_quotient = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [20:0] slope0, slope1, slope2;
   logic [2:0]         horiz, timeout_err;

   int   n_checks = 0;
   int   n_err = 0;
   int   div_lat = 3;
   int   force_req = 0;
   int   force_seen = 0;
   int   pend_rem = 0;
   int   lat_pick = 0;
   logic signed [20:0] pend_q = '0;
   int   log_dvd[$];
   int   log_dvs[$];
   int   log_rd = 0;
   vec_t exp_q[$];

   always #5 clk = ~clk;

   edge_slope_setup #(.FRAC_BITS(FRAC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
      .div_open(div_open), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_finish(div_finish), .div_quotient(div_quotient),
      .out_valid(out_valid), .out_ready(out_ready),
      .slope0(slope0), .slope1(slope1), .slope2(slope2),
      .horiz(horiz), .timeout_err(timeout_err)
   );

   // Behavioural divider: answers 'lat' cycles after each open, logs every open.
   always @(negedge clk) begin
      div_finish = 1'b0;
      if (!rst_n) pend_rem = 0;
      if (force_req != force_seen) begin
         force_seen   = force_req;
         div_finish   = 1'b1;
         div_quotient = 21'sd777;
      end else if (pend_rem > 0) begin
         pend_rem = pend_rem - 1;
         if (pend_rem == 0) begin
            div_finish   = 1'b1;
            div_quotient = pend_q;
         end
      end
      if (div_open) begin
         log_dvd.push_back(int'(div_dividend));
         log_dvs.push_back(int'(div_divisor));
         pend_q   = (div_divisor == 21'sd0) ? 21'sd0 : 21'(int'(div_dividend) / int'(div_divisor));
         lat_pick = (div_lat < 0) ? int'($urandom_range(1, 20)) : div_lat;
         pend_rem = lat_pick;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void edge_model(input vec_t v, input int k, output int dvd, output int dvs);
      int nb;
      nb  = (k + 1) % 3;
      dvd = (v.x[nb] - v.x[k]) * (1 << FRAC);
      dvs = v.y[nb] - v.y[k];
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      int   dvd, dvs;
      for (int k = 0; k < 3; k++) begin
         v.x[k] = int'($urandom_range(0, 65534)) - 32767;
         v.y[k] = int'($urandom_range(0, 65534)) - 32767;
      end
      v.lat = -1;
      v.hz  = '0;
      v.te  = '0;
      for (int k = 0; k < 3; k++) begin
         edge_model(v, k, dvd, dvs);
         v.hz[k] = (dvs == 0);
         v.s[k]  = (dvs == 0) ? 0 : dvd / dvs;
      end
      return v;
   endfunction

   task automatic drive_tri(input vec_t v);
      v0_x = 16'(v.x[0]); v0_y = 16'(v.y[0]);
      v1_x = 16'(v.x[1]); v1_y = 16'(v.y[1]);
      v2_x = 16'(v.x[2]); v2_y = 16'(v.y[2]);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_tri(input vec_t v, input int hold);
      vec_t e;
      int   n, nz, rd0, dvd, dvs, lat_exp;
      bit   ok;
      exp_q.push_back(v);
      div_lat = v.lat;
      @(negedge clk);
      check("in_ready_idle", longint'(in_ready), 1);
      rd0 = log_dvd.size();
      drive_tri(v);
      n  = 1;
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      if (!ok) begin
         check("out_valid_timeout", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      check("slope0", longint'(slope0), longint'(e.s[0]));
      check("slope1", longint'(slope1), longint'(e.s[1]));
      check("slope2", longint'(slope2), longint'(e.s[2]));
      check("horiz", longint'(horiz), longint'(e.hz));
      check("timeout_err", longint'(timeout_err), longint'(e.te));
      nz      = 0;
      lat_exp = 1;
      for (int k = 0; k < 3; k++) begin
         edge_model(v, k, dvd, dvs);
         if (dvs == 0) begin
            lat_exp += 1;
         end else begin
            nz++;
            lat_exp += 1 + ((v.lat == 0) ? TO : v.lat);
            if (log_rd < log_dvd.size()) begin
               check("div_dividend", longint'(log_dvd[log_rd]), longint'(dvd));
               check("div_divisor", longint'(log_dvs[log_rd]), longint'(dvs));
               log_rd++;
            end else begin
               check("div_missing_open", 0, 1);
            end
         end
      end
      check("div_open_count", longint'(log_dvd.size() - rd0), longint'(nz));
      log_rd = log_dvd.size();
      if (v.lat >= 0) check("latency", longint'(n), longint'(lat_exp));
      for (int c = 0; c < hold; c++) begin
         if (c == 5) begin
            v0_x = 16'sd123; v1_y = -16'sd77;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         check("hold_out_valid", longint'(out_valid), 1);
         check("hold_in_ready", longint'(in_ready), 0);
         check("hold_slope1", longint'(slope1), longint'(e.s[1]));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("release_out_valid", longint'(out_valid), 0);
      check("release_in_ready", longint'(in_ready), 1);
      rd0 = log_dvd.size();
      repeat (2) @(negedge clk);
      check("idle_no_open", longint'(log_dvd.size() - rd0), 0);
   endtask

   initial begin
      vec_t tbl[5];
      vec_t rv;
      bit   ok;
      int   rd0;
      tbl[0] = '{x:'{0, 10, 0},    y:'{0, 5, 10},    lat:3, s:'{32, -32, 0},    hz:3'b000, te:3'b000};
      tbl[1] = '{x:'{0, 8, 4},     y:'{0, 0, 4},     lat:2, s:'{0, -16, 16},    hz:3'b001, te:3'b000};
      tbl[2] = '{x:'{7, 7, 7},     y:'{7, 7, 7},     lat:3, s:'{0, 0, 0},       hz:3'b111, te:3'b000};
      tbl[3] = '{x:'{0, 10, 0},    y:'{0, 5, 10},    lat:0, s:'{0, 0, 0},       hz:3'b000, te:3'b111};
      tbl[4] = '{x:'{-100, 300, 1}, y:'{-50, -47, 2}, lat:5, s:'{2133, -97, 31}, hz:3'b000, te:3'b000};

      repeat (3) @(negedge clk);
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_div_open", longint'(div_open), 0);
      check("rst_dividend", longint'(div_dividend), 0);
      check("rst_slope0", longint'(slope0), 0);
      check("rst_horiz", longint'(horiz), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_tri(tbl[i], 0);

      // Stale finish in IDLE must not touch the held slopes.
      force_req++;
      repeat (3) @(negedge clk);
      check("stale_finish_slope0", longint'(slope0), 2133);
      check("stale_finish_in_ready", longint'(in_ready), 1);

      // Back-pressure in DONE with a spurious in_valid pulse.
      run_tri(tbl[0], 20);

      // Reset while waiting on edge1's quotient.
      div_lat = 3;
      @(negedge clk);
      rd0 = log_dvd.size();
      drive_tri(tbl[0]);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (log_dvd.size() - rd0 >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_reach_wait", longint'(ok), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", longint'(in_ready), 1);
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_div_open", longint'(div_open), 0);
      check("midrst_dividend", longint'(div_dividend), 0);
      check("midrst_divisor", longint'(div_divisor), 0);
      check("midrst_slope0", longint'(slope0), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      force_req++;
      repeat (3) @(negedge clk);
      check("late_finish_slope0", longint'(slope0), 0);
      check("late_finish_slope1", longint'(slope1), 0);
      check("late_finish_horiz", longint'(horiz), 0);
      check("late_finish_terr", longint'(timeout_err), 0);
      check("late_finish_in_ready", longint'(in_ready), 1);
      check("late_finish_out_valid", longint'(out_valid), 0);
      log_rd = log_dvd.size();

      run_tri(tbl[1], 0);

      for (int i = 0; i < 20; i++) begin
         rv = rand_vec();
         run_tri(rv, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end
endmodule
